// File: rtl/lia_boxcar_decimator_if.sv
// Stream bundle of the boxcar decimator: mixer product in, decimated average out.
interface lia_boxcar_decimator_if #(
    parameter int unsigned INPUT_WIDTH  = 14,
    parameter int unsigned OUTPUT_WIDTH = 16
);
    logic signed [INPUT_WIDTH-1:0]  in_data;
    logic                           in_valid;
    logic                           sync;
    logic signed [OUTPUT_WIDTH-1:0] out_data;
    logic                           out_valid;
    logic                           out_sat;

    // Producer of the mixer stream / consumer of the averaged result.
    modport master (
        output in_data,
        output in_valid,
        output sync,
        input  out_data,
        input  out_valid,
        input  out_sat
    );

    // The decimator itself.
    modport slave (
        input  in_data,
        input  in_valid,
        input  sync,
        output out_data,
        output out_valid,
        output out_sat
    );
endinterface

// File: rtl/lia_boxcar_decimator.sv
// Integrate-and-dump boxcar decimator: averages 2^log2_n mixer products,
// applies a power-of-two gain with saturation, strobes one word per window.
module lia_boxcar_decimator #(
    parameter int unsigned INPUT_WIDTH  = 14,
    parameter int unsigned OUTPUT_WIDTH = 16,
    parameter int unsigned MAX_LOG2_N   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [4:0]            log2_n_i,
    input  logic [2:0]            gain_shift_i,
    lia_boxcar_decimator_if.slave bus
);

    localparam int unsigned LOG2_WIDTH = 5;
    localparam int unsigned GAIN_WIDTH = 3;
    localparam int unsigned MAX_GAIN   = 7;
    localparam int unsigned ACC_WIDTH  = INPUT_WIDTH + MAX_LOG2_N;
    localparam int unsigned CNT_WIDTH  = MAX_LOG2_N + 1;
    localparam int unsigned SCL_WIDTH  = ACC_WIDTH + MAX_GAIN;
    localparam int unsigned HI_WIDTH   = SCL_WIDTH - OUTPUT_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t                        state_q,     state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q,       acc_d;
    logic        [CNT_WIDTH-1:0]   cnt_q,       cnt_d;
    logic        [LOG2_WIDTH-1:0]  win_log2_q,  win_log2_d;
    logic        [GAIN_WIDTH-1:0]  win_gain_q,  win_gain_d;
    logic signed [ACC_WIDTH-1:0]   dump_q,      dump_d;
    logic        [LOG2_WIDTH-1:0]  dump_log2_q, dump_log2_d;
    logic        [GAIN_WIDTH-1:0]  dump_gain_q, dump_gain_d;
    logic                          dump_vld_q,  dump_vld_d;
    logic signed [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          out_sat_q,   out_sat_d;

    logic        [LOG2_WIDTH-1:0]  log2_clamped;
    logic signed [ACC_WIDTH-1:0]   sample_ext;
    logic signed [ACC_WIDTH-1:0]   base_acc;
    logic        [CNT_WIDTH-1:0]   base_cnt;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic                          first;
    logic        [LOG2_WIDTH-1:0]  eff_log2;
    logic        [GAIN_WIDTH-1:0]  eff_gain;
    logic        [CNT_WIDTH-1:0]   win_last;
    logic signed [ACC_WIDTH-1:0]   mean;
    logic signed [SCL_WIDTH-1:0]   scaled;
    logic        [HI_WIDTH-1:0]    scaled_hi;
    logic                          over;

    // Window sizes beyond what the accumulator is built for fold to the maximum.
    assign log2_clamped = (log2_n_i > LOG2_WIDTH'(MAX_LOG2_N)) ? LOG2_WIDTH'(MAX_LOG2_N)
                                                               : log2_n_i;

    // Sync restarts the window on this very edge, so the accumulation base is zero.
    assign sample_ext = ACC_WIDTH'(bus.in_data);
    assign base_acc   = bus.sync ? '0 : acc_q;
    assign base_cnt   = bus.sync ? '0 : cnt_q;
    assign acc_sum    = base_acc + sample_ext;

    // The first sample of a window uses the live parameters it latches.
    assign first    = (base_cnt == '0);
    assign eff_log2 = first ? log2_clamped : win_log2_q;
    assign eff_gain = first ? gain_shift_i : win_gain_q;
    assign win_last = (CNT_WIDTH'(1) << eff_log2) - CNT_WIDTH'(1);

    // Output datapath: floor mean, full-width gain, overflow when high bits disagree.
    assign mean      = dump_q >>> dump_log2_q;
    assign scaled    = SCL_WIDTH'(mean) <<< dump_gain_q;
    assign scaled_hi = scaled[SCL_WIDTH-1:OUTPUT_WIDTH-1];
    assign over      = !((&scaled_hi) || !(|scaled_hi));

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            win_log2_q  <= '0;
            win_gain_q  <= '0;
            dump_q      <= '0;
            dump_log2_q <= '0;
            dump_gain_q <= '0;
            dump_vld_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            win_log2_q  <= win_log2_d;
            win_gain_q  <= win_gain_d;
            dump_q      <= dump_d;
            dump_log2_q <= dump_log2_d;
            dump_gain_q <= dump_gain_d;
            dump_vld_q  <= dump_vld_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
        end
    end

    // Next-state: window accumulation, dump on sample N, then the output stage.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        win_log2_d  = win_log2_q;
        win_gain_d  = win_gain_q;
        dump_d      = dump_q;
        dump_log2_d = dump_log2_q;
        dump_gain_d = dump_gain_q;
        dump_vld_d  = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = dump_vld_q;
        out_sat_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (en_i) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (bus.in_valid) begin
                    if (first) begin
                        win_log2_d = log2_clamped;
                        win_gain_d = gain_shift_i;
                    end
                    if (base_cnt == win_last) begin
                        dump_d      = acc_sum;
                        dump_log2_d = eff_log2;
                        dump_gain_d = eff_gain;
                        dump_vld_d  = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = base_cnt + CNT_WIDTH'(1);
                    end
                end else begin
                    acc_d = base_acc;
                    cnt_d = base_cnt;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A dump already taken always finishes, independent of en/sync.
        if (dump_vld_q) begin
            out_sat_d = over;
            if (!over) begin
                out_data_d = scaled[OUTPUT_WIDTH-1:0];
            end else if (scaled[SCL_WIDTH-1]) begin
                out_data_d = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
            end else begin
                out_data_d = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_lia_boxcar_decimator.sv
// Bench for the boxcar decimator: directed scenarios plus a randomized run
// against a window-level reference model.
module tb_lia_boxcar_decimator;

    localparam int unsigned IW = 14;
    localparam int unsigned OW = 16;
    localparam int unsigned ML = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] log2_n;
    logic [2:0] gain;

    lia_boxcar_decimator_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

    lia_boxcar_decimator #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .MAX_LOG2_N  (ML)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .log2_n_i    (log2_n),
        .gain_shift_i(gain),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // Observed output pulses (data, cycle number, saturation flag).
    longint pq_data[$];
    int     pq_cyc[$];
    bit     pq_sat[$];

    // Reference model: samples of the open window and the pending result.
    bit     m_active;
    int     m_win[$];
    int     m_n, m_g;
    bit     m_pend;
    longint m_pend_sum;
    int     m_pend_n, m_pend_g;
    bit     exp_valid, exp_sat;
    longint exp_data;

    function automatic void model_reset();
        m_active  = 1'b0;
        m_win.delete();
        m_n = 0; m_g = 0;
        m_pend    = 1'b0;
        exp_valid = 1'b0;
        exp_sat   = 1'b0;
        exp_data  = 0;
    endfunction

    // mean = floor(sum / 2^n), scaled by 2^g, clamped to the output range.
    function automatic void calc(input longint sum, input int n, input int g,
                                 output longint v, output bit s);
        longint d;
        longint q;
        d = longint'(1) << n;
        q = sum / d;
        if ((sum % d) != 0 && sum < 0) q = q - 1;
        q = q * (longint'(1) << g);
        s = 1'b0;
        v = q;
        if (q > 32767)       begin v = 32767;  s = 1'b1; end
        else if (q < -32768) begin v = -32768; s = 1'b1; end
    endfunction

    function automatic void model_edge(input bit e, input bit v, input int d,
                                       input bit s, input int l2, input int g);
        longint sum;
        if (m_pend) begin
            calc(m_pend_sum, m_pend_n, m_pend_g, exp_data, exp_sat);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
            exp_sat   = 1'b0;
        end
        m_pend = 1'b0;
        if (!m_active) begin
            if (e) m_active = 1'b1;
        end else if (!e) begin
            m_active = 1'b0;
            m_win.delete();
        end else begin
            if (s) m_win.delete();
            if (v) begin
                if (m_win.size() == 0) begin
                    m_n = (l2 > int'(ML)) ? int'(ML) : l2;
                    m_g = g;
                end
                m_win.push_back(d);
                if (m_win.size() == (1 << m_n)) begin
                    sum = 0;
                    foreach (m_win[i]) sum += longint'(m_win[i]);
                    m_pend     = 1'b1;
                    m_pend_sum = sum;
                    m_pend_n   = m_n;
                    m_pend_g   = m_g;
                    m_win.delete();
                end
            end
        end
    endfunction

    // One clock: drive inputs, advance model at the edge, sample #1 later.
    task automatic cyc(input bit v, input int d, input bit s);
        bus.in_valid = v;
        bus.in_data  = IW'(d);
        bus.sync     = s;
        @(posedge clk);
        model_edge(en, v, d, s, int'(log2_n), int'(gain));
        #1;
        cyc_n++;
        if (bus.out_valid === 1'b1) begin
            pq_data.push_back(longint'($signed(bus.out_data)));
            pq_cyc.push_back(cyc_n);
            pq_sat.push_back(bus.out_sat);
        end
    endtask

    task automatic clear_pulses();
        pq_data.delete();
        pq_cyc.delete();
        pq_sat.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; log2_n = 5'd2; gain = 3'd0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.sync = 1'b0;
        #3;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_sat !== 1'b0 || bus.out_data !== 16'sd0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b sat=%b data=%0d, required 0 0 0",
                     bus.out_valid, bus.out_sat, bus.out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        en = 1'b1; log2_n = 5'd2; gain = 3'd0;
        cyc(1'b1, 99, 1'b0);
        for (int i = 1; i <= 4; i++) cyc(1'b1, i, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early: valid=%b one edge after sample 4, required 0", bus.out_valid);
        end
        cyc(1'b0, 0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd2 || bus.out_sat !== 1'b0) begin
            bad++;
            $display("FAIL basic_out: valid=%b data=%0d sat=%b, required 1 2 0",
                     bus.out_valid, bus.out_data, bus.out_sat);
        end
        cyc(1'b0, 0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd2 || bus.out_sat !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold: valid=%b data=%0d sat=%b, required 0 2 0",
                     bus.out_valid, bus.out_data, bus.out_sat);
        end
    endtask

    task automatic test_floor_back_to_back();
        int seq[10] = '{-1, -1, -1, -2, 4, 4, 4, 4, 0, 0};
        clear_pulses();
        for (int i = 0; i < 10; i++) cyc(i < 8, seq[i], 1'b0);
        total++;
        if (pq_data.size() != 2) begin
            bad++;
            $display("FAIL floor_count: pulses=%0d, required 2", pq_data.size());
        end else begin
            total++;
            if (pq_data[0] != -2) begin
                bad++;
                $display("FAIL floor_value: data=%0d, required -2", pq_data[0]);
            end
            total++;
            if (pq_data[1] != 4) begin
                bad++;
                $display("FAIL b2b_value: data=%0d, required 4", pq_data[1]);
            end
            total++;
            if (pq_cyc[1] - pq_cyc[0] != 4) begin
                bad++;
                $display("FAIL b2b_spacing: spacing=%0d, required 4", pq_cyc[1] - pq_cyc[0]);
            end
        end
    endtask

    task automatic test_gain_sat();
        int     smp[3]  = '{8191, -8192, 100};
        longint want[3] = '{32767, -32768, 12800};
        bit     wsat[3] = '{1'b1, 1'b1, 1'b0};
        log2_n = 5'd0; gain = 3'd7;
        clear_pulses();
        for (int i = 0; i < 4; i++) cyc(i < 3, (i < 3) ? smp[i] : 0, 1'b0);
        total++;
        if (pq_data.size() != 3) begin
            bad++;
            $display("FAIL gain_count: pulses=%0d, required 3", pq_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (pq_data[i] != want[i] || pq_sat[i] != wsat[i]) begin
                    bad++;
                    $display("FAIL gain_sat_%0d: data=%0d sat=%b, required %0d %b",
                             i, pq_data[i], pq_sat[i], want[i], wsat[i]);
                end
            end
        end
        cyc(1'b0, 0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_sat !== 1'b0 || bus.out_data !== 16'sd12800) begin
            bad++;
            $display("FAIL gain_idle: valid=%b sat=%b data=%0d, required 0 0 12800",
                     bus.out_valid, bus.out_sat, bus.out_data);
        end
    endtask

    task automatic test_irregular_valid();
        bit [19:0] pat = 20'b0110_1001_0101_0001_1000;
        int        last_v = 0;
        int        start;
        log2_n = 5'd3; gain = 3'd0;
        clear_pulses();
        start = cyc_n;
        for (int i = 0; i < 23; i++) begin
            if (i < 20 && pat[i]) begin
                cyc(1'b1, 100, 1'b0);
                last_v = cyc_n;
            end else begin
                cyc(1'b0, int'($urandom_range(0, 16383)) - 8192, 1'b0);
            end
        end
        total++;
        if (pq_data.size() != 1) begin
            bad++;
            $display("FAIL irregular_count: pulses=%0d, required 1", pq_data.size());
        end else begin
            total++;
            if (pq_data[0] != 100 || pq_cyc[0] != last_v + 1) begin
                bad++;
                $display("FAIL irregular_out: data=%0d at cycle %0d, required 100 at cycle %0d",
                         pq_data[0], pq_cyc[0] - start, last_v + 1 - start);
            end
        end
    endtask

    task automatic test_sync();
        log2_n = 5'd2; gain = 3'd0;
        clear_pulses();
        cyc(1'b1, 10, 1'b0);
        cyc(1'b1, 10, 1'b0);
        cyc(1'b1, 50, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 50, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        total++;
        if (pq_data.size() != 1 || pq_data[0] != 50) begin
            bad++;
            $display("FAIL sync_restart: pulses=%0d first=%0d, required 1 pulse of 50",
                     pq_data.size(), (pq_data.size() > 0) ? pq_data[0] : 0);
        end
        clear_pulses();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1, 1'b0);
        cyc(1'b1, 1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0);
        total++;
        if (pq_data.size() != 0) begin
            bad++;
            $display("FAIL sync_on_last: pulses=%0d, required 0", pq_data.size());
        end
        clear_pulses();
        cyc(1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 7, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        total++;
        if (pq_data.size() != 1 || pq_data[0] != 7) begin
            bad++;
            $display("FAIL sync_clear: pulses=%0d first=%0d, required 1 pulse of 7",
                     pq_data.size(), (pq_data.size() > 0) ? pq_data[0] : 0);
        end
    endtask

    task automatic test_param_change_and_rst();
        int start;
        log2_n = 5'd2; gain = 3'd0;
        clear_pulses();
        start = cyc_n;
        cyc(1'b1, 20, 1'b0);
        cyc(1'b1, 20, 1'b0);
        log2_n = 5'd1;
        cyc(1'b1, 20, 1'b0);
        cyc(1'b1, 20, 1'b0);
        cyc(1'b1, 30, 1'b0);
        cyc(1'b1, 30, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        total++;
        if (pq_data.size() != 2) begin
            bad++;
            $display("FAIL param_count: pulses=%0d, required 2", pq_data.size());
        end else begin
            total++;
            if (pq_cyc[0] != start + 5 || pq_data[0] != 20 ||
                pq_cyc[1] != start + 7 || pq_data[1] != 30) begin
                bad++;
                $display("FAIL param_latch: pulses %0d@%0d %0d@%0d, required 20@5 30@7",
                         pq_data[0], pq_cyc[0] - start, pq_data[1], pq_cyc[1] - start);
            end
        end
        cyc(1'b1, 5, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_sat !== 1'b0 || bus.out_data !== 16'sd0) begin
            bad++;
            $display("FAIL rst_async: valid=%b sat=%b data=%0d, required 0 0 0",
                     bus.out_valid, bus.out_sat, bus.out_data);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_pulses();
        cyc(1'b1, 99, 1'b0);
        cyc(1'b1, 6, 1'b0);
        cyc(1'b1, 6, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        total++;
        if (pq_data.size() != 1 || pq_data[0] != 6) begin
            bad++;
            $display("FAIL rst_restart: pulses=%0d first=%0d, required 1 pulse of 6",
                     pq_data.size(), (pq_data.size() > 0) ? pq_data[0] : 0);
        end
    endtask

    task automatic test_random();
        bit     v, s;
        int     d;
        longint got;
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 7) == 0)
                log2_n = ($urandom_range(0, 49) == 0) ? 5'($urandom_range(17, 31))
                                                      : 5'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) gain = 3'($urandom_range(0, 7));
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 29) == 0);
            d = int'($urandom_range(0, 16383)) - 8192;
            cyc(v, d, s);
            got = longint'($signed(bus.out_data));
            total++;
            if (bus.out_valid !== exp_valid || bus.out_sat !== exp_sat || got != exp_data) begin
                bad++;
                if (bad <= 20)
                    $display("FAIL random_cyc%0d: valid=%b sat=%b data=%0d, required valid=%b sat=%b data=%0d",
                             i, bus.out_valid, bus.out_sat, got, exp_valid, exp_sat, exp_data);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_floor_back_to_back();
        test_gain_sat();
        test_irregular_valid();
        test_sync();
        test_param_change_and_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lia_boxcar_decimator.md
Name: lia_boxcar_decimator

Overview:
Integrate-and-dump low-pass/decimation stage that consumes the signed product stream of the lock-in mixer. It averages 2^log2_n valid samples into one output word, applies a programmable power-of-two gain with saturation, and emits one output per window with a single-cycle valid strobe. Its output feeds the lock-in readout/PI loop at the decimated rate.

Parameters:
INPUT_WIDTH, 14, width of the signed mixer product input
OUTPUT_WIDTH, 16, width of the signed averaged output
MAX_LOG2_N, 16, largest supported window exponent; accumulator width ACC_WIDTH = INPUT_WIDTH + MAX_LOG2_N (local, derived)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  enable; low forces IDLE and discards the partial window
in_data  in  INPUT_WIDTH  signed mixer product
in_valid  in  1  in_data qualifier
sync  in  1  window restart pulse
log2_n  in  5  window length exponent, N = 2^log2_n; values above MAX_LOG2_N clamp to MAX_LOG2_N
gain_shift  in  3  post-average left shift, 0..7
out_data  out  OUTPUT_WIDTH  signed averaged, scaled, saturated result
out_valid  out  1  one-cycle strobe per completed window
out_sat  out  1  high with out_valid when out_data was clamped; otherwise 0

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; accumulator, sample counter, dump register, out_data, out_valid and out_sat all 0.
- States: IDLE, ACCUM.
- IDLE: accumulator and counter held at 0; no samples accepted. Transition to ACCUM on the first clock edge with en=1. That edge does not accept a sample.
- ACCUM: each edge with in_valid=1 adds sign-extended in_data into the ACC_WIDTH accumulator and increments the counter.
- en=0 in ACCUM: transition to IDLE at the next edge; partial window discarded.
- Window start: log2_n (clamped) and gain_shift are latched when the first sample of a window is accepted. Changes mid-window take effect only at the next window.
- Window completion: the edge accepting sample number N transfers (accumulator + in_data) to the dump register. The same edge reloads the accumulator and counter to 0, so the next valid sample (even on the very next cycle) is sample 1 of the new window. No sample is ever dropped between windows.
- Output stage (one edge after the dump):
  - mean = dump >>> latched log2_n (arithmetic shift, floor toward minus infinity).
  - scaled = mean <<< latched gain_shift, computed at full width.
  - Saturate scaled to the range [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
  - Register out_data and out_sat, and pulse out_valid high for exactly one cycle.
- Latency: last sample captured at edge k, so out_valid is high in the cycle after edge k+1 (2 edges). out_data holds its value until the next out_valid. out_sat is 0 whenever out_valid is 0.
- log2_n=0: every valid sample produces an output (pass-through with gain and saturation).
- sync=1 in ACCUM: the partial window is discarded.
  - If in_valid=1 in the same cycle, that sample becomes sample 1 of the new window, with parameters latched then.
  - If in_valid=0, the accumulator and counter clear to 0.
  - sync coinciding with what would be sample N: sync wins; no dump and no output.
  - sync in IDLE is ignored.
- A dump already taken completes its output stage even if en drops or sync arrives on the following cycle.
- The accumulator cannot overflow: ACC_WIDTH covers N = 2^MAX_LOG2_N full-scale samples.

Test Plan:
1. log2_n=2, gain_shift=0, consecutive valid samples 1,2,3,4 -> single out_valid pulse 2 edges after sample 4, out_data=2 (10>>>2), out_sat=0.
2. log2_n=2, samples -1,-1,-1,-2 -> out_data=-2 (floor of -5/4); then samples 4,4,4,4 back-to-back -> out_data=4, exactly 4 cycles after the previous out_valid.
3. log2_n=0, gain_shift=7, in_data=8191 -> out_data=32767, out_sat=1; in_data=-8192 -> out_data=-32768, out_sat=1; in_data=100 -> out_data=12800, out_sat=0.
4. log2_n=3, eight samples of 100 with in_valid toggling irregularly over 20 cycles -> exactly one out_valid, after the 8th valid sample, with out_data=100.
5. log2_n=2, samples 10,10, then sync together with sample 50, then 50,50,50 -> exactly one output, out_data=50. Also: sync coincident with a 4th sample -> no output for that window.
6. Change log2_n from 2 to 1 after sample 2 of a window -> that window still closes after 4 samples; the next closes after 2. Assert rst mid-window -> all outputs 0 immediately, and the block restarts from IDLE.
